// File: rtl/ifetch.sv
// ifetch: fetch PC owner, in-order imem requester, instruction buffer and decode-facing output register.
// Revision: 1.0
`default_nettype none

module ifetch #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [31:0]     NOP_INSTR  = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_adr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            stall_i,
  input  logic            flush_v_q_i,
  input  logic [XLEN-1:0] branch_adr_q_i,
  output logic [31:0]     instr_q_o,
  output logic [XLEN-1:0] pc0_q_o,
  output logic            instr_v_q_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_f_q, pc_f_d, rpc_q, rpc_d, pc0_q, pc0_d;
  logic [CW-1:0]   outst_q, outst_d, kill_q, kill_d, cnt_q, cnt_d;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [31:0]     instr_q, instr_d;
  logic            instr_v_q, instr_v_d;
  logic [31:0]     fifo_instr_q [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc_q    [FIFO_DEPTH];

  logic            credit, gnt_acc, live, bypass, pop, push;
  logic [XLEN-1:0] target;

  // Credit counts both in-flight and buffered words so a response can never overflow the FIFO.
  assign credit     = ({1'b0, outst_q} + {1'b0, cnt_q}) < (CW + 1)'(FIFO_DEPTH);
  assign imem_req_o = reset_n & ~flush_v_q_i & credit;
  assign imem_adr_o = pc_f_q;
  assign gnt_acc    = imem_req_o & imem_gnt_i;
  assign live       = imem_rvalid_i & (kill_q == '0) & ~flush_v_q_i;
  assign bypass     = live & ~stall_i & (cnt_q == '0);
  assign pop        = ~flush_v_q_i & ~stall_i & (cnt_q != '0);
  assign push       = live & ~bypass;
  assign target     = {branch_adr_q_i[XLEN-1:2], 2'b00};

  always_comb begin
    pc_f_d    = pc_f_q;
    rpc_d     = rpc_q;
    outst_d   = outst_q + CW'(gnt_acc) - CW'(imem_rvalid_i);
    kill_d    = kill_q;
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    wr_d      = wr_q + PW'(push);
    rd_d      = rd_q + PW'(pop);
    instr_d   = instr_q;
    instr_v_d = instr_v_q;
    pc0_d     = pc0_q;
    if (flush_v_q_i) begin
      pc_f_d    = target;
      rpc_d     = target;
      // Every response still in flight after this cycle belongs to the old path.
      kill_d    = outst_q - CW'(imem_rvalid_i);
      cnt_d     = '0;
      wr_d      = '0;
      rd_d      = '0;
      instr_d   = NOP_INSTR;
      instr_v_d = 1'b0;
    end else begin
      if (gnt_acc)
        pc_f_d = pc_f_q + XLEN'(4);
      if (live)
        rpc_d = rpc_q + XLEN'(4);
      else if (imem_rvalid_i)
        kill_d = kill_q - CW'(1);
      if (!stall_i) begin
        if (pop) begin
          instr_d   = fifo_instr_q[rd_q];
          pc0_d     = fifo_pc_q[rd_q];
          instr_v_d = 1'b1;
        end else if (bypass) begin
          instr_d   = imem_rdata_i;
          pc0_d     = rpc_q;
          instr_v_d = 1'b1;
        end else begin
          instr_d   = NOP_INSTR;
          instr_v_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_f_q    <= RESET_PC;
      rpc_q     <= RESET_PC;
      outst_q   <= '0;
      kill_q    <= '0;
      cnt_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      instr_q   <= NOP_INSTR;
      instr_v_q <= 1'b0;
      pc0_q     <= '0;
    end else begin
      pc_f_q    <= pc_f_d;
      rpc_q     <= rpc_d;
      outst_q   <= outst_d;
      kill_q    <= kill_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      instr_q   <= instr_d;
      instr_v_q <= instr_v_d;
      pc0_q     <= pc0_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_q] <= imem_rdata_i;
      fifo_pc_q[wr_q]    <= rpc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(imem_rvalid_i && outst_q == '0));
      assert (outst_q <= CW'(FIFO_DEPTH));
    end
  end

  assign instr_q_o   = instr_q;
  assign pc0_q_o     = pc0_q;
  assign instr_v_q_o = instr_v_q;

endmodule

`default_nettype wire
